// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB/TRAP controller for an RV32I core: owns pc and instret and drives the memory handshakes.
// Optional MEM_TIMEOUT_EN: bounds FETCH/MEM waits to TIMEOUT cycles and traps on expiry.
module multicycle_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32,
  parameter int          TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             branch_taken,
  input  logic [31:0]      target,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic [31:0]      pc,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             alu_src_imm,
  output logic             alu_a_pc,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic [CNT_W-1:0] instret,
  output logic             halt
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

  state_t state, state_next;
  logic   live;

  logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
  logic is_opimm, is_op, is_illegal, writes, xfer, misalign, timeout_hit;

  assign is_lui     = (opcode == 6'd0);
  assign is_auipc   = (opcode == 6'd1);
  assign is_jal     = (opcode == 6'd2);
  assign is_jalr    = (opcode == 6'd3);
  assign is_branch  = (opcode >= 6'd4)  && (opcode <= 6'd9);
  assign is_load    = (opcode >= 6'd10) && (opcode <= 6'd14);
  assign is_store   = (opcode >= 6'd15) && (opcode <= 6'd17);
  assign is_opimm   = (opcode >= 6'd18) && (opcode <= 6'd26);
  assign is_op      = (opcode >= 6'd27) && (opcode <= 6'd36);
  assign is_illegal = (opcode == 6'd63);

  assign writes   = is_lui | is_auipc | is_jal | is_jalr | is_load | is_opimm | is_op;
  assign xfer     = is_jal | is_jalr | (is_branch & branch_taken);
  assign misalign = xfer & target[1];

`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || (state_next != state))
      wait_cnt <= '0;
    else if (imem_req || dmem_req)
      wait_cnt <= wait_cnt + 1'b1;
  end

  // Last permitted wait cycle; a ready arriving in this same cycle still wins.
  assign timeout_hit = (wait_cnt == TW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      live  <= 1'b0;
    end else begin
      state <= state_next;
      live  <= 1'b1;
    end
  end

  // live holds imem_req low for the first cycle after reset so an in-flight fetch is dropped.
  always_comb begin
    // NOTE: every output gets a default before the case so no path through it can infer a latch.
    state_next  = state;
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    alu_src_imm = 1'b0;
    alu_a_pc    = 1'b0;
    rf_we       = 1'b0;
    wb_sel      = 2'd0;
    halt        = 1'b0;
    case (state)
      FETCH: begin
        imem_req = live;
        ir_we    = live & imem_ready;
        if (ir_we)                    state_next = DECODE;
        else if (live && timeout_hit) state_next = TRAP;
      end
      DECODE: state_next = is_illegal ? TRAP : EXEC;
      EXEC:   state_next = (is_load || is_store) ? MEM : WB;
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ready)       state_next = WB;
        else if (timeout_hit) state_next = TRAP;
      end
      WB: begin
        if (misalign) begin
          state_next = TRAP;
        end else begin
          rf_we      = writes;
          wb_sel     = is_load ? 2'd1 : (is_jal || is_jalr) ? 2'd2 : is_lui ? 2'd3 : 2'd0;
          state_next = FETCH;
        end
      end
      TRAP:    halt = 1'b1;
      default: state_next = FETCH;
    endcase
    if (state == EXEC || state == MEM || state == WB) begin
      alu_a_pc    = is_auipc | is_jal | is_branch;
      alu_src_imm = is_auipc | is_jal | is_jalr | is_branch | is_load | is_store | is_opimm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      instret <= '0;
    end else if (state == WB && !misalign) begin
      pc      <= xfer ? {target[31:1], target[0] & ~is_jalr} : pc + 32'd4;
      instret <= instret + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a table of single-instruction vectors plus hand sequences for trap, reset and timeout.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = 6'd0;
  logic        branch_taken = 1'b0;
  logic [31:0] target = 32'h0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic [31:0] pc;
  logic        imem_req, ir_we, dmem_req, dmem_we, alu_src_imm, alu_a_pc, rf_we, halt;
  logic [1:0]  wb_sel;
  logic [31:0] instret;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken), .target(target),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .pc(pc), .imem_req(imem_req),
    .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we), .alu_src_imm(alu_src_imm),
    .alu_a_pc(alu_a_pc), .rf_we(rf_we), .wb_sel(wb_sel), .instret(instret), .halt(halt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  opcode;
    int          iwait;
    int          dwait;
    bit          taken;
    logic [31:0] target;
    int          cycles;
    int          rf_n;
    logic [1:0]  wbsel;
    int          dreq;
    bit          dwe;
    bit          imm;
    bit          apc;
    bit          halt;
    logic [31:0] pc;
    logic [31:0] instret;
  } vec_t;

  typedef struct {
    bit          done;
    int          cycles;
    int          rf_n;
    logic [1:0]  wbsel;
    int          dreq;
    bit          dwe;
    bit          imm;
    bit          apc;
    bit          halt;
    logic [31:0] pc;
    logic [31:0] instret;
  } obs_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Runs one instruction from its first fetch request until the next fetch request or halt.
  task automatic run_instr(input vec_t v, output obs_t o);
    int  ireq = 0;
    int  dreq = 0;
    bit  started = 0;
    bit  fetched = 0;
    o = '{done: 0, cycles: 0, rf_n: 0, wbsel: 2'd0, dreq: 0, dwe: 0, imm: 0, apc: 0,
          halt: 0, pc: 32'h0, instret: 32'h0};
    opcode       = v.opcode;
    branch_taken = v.taken;
    target       = v.target;
    #1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (halt) begin o.done = 1; o.halt = 1; break; end
      if (imem_req && fetched) begin o.done = 1; break; end
      if (imem_req) started = 1;
      if (started) o.cycles++;
      if (imem_req) begin
        imem_ready = (ireq >= v.iwait);
        ireq++;
        if (imem_ready) fetched = 1;
      end else begin
        imem_ready = 1'b0;
      end
      if (dmem_req) begin
        dmem_ready = (dreq >= v.dwait);
        dreq++;
        o.dreq++;
        if (dmem_we) o.dwe = 1;
      end else begin
        dmem_ready = 1'b0;
      end
      if (rf_we) begin o.rf_n++; o.wbsel = wb_sel; end
      o.imm |= alu_src_imm;
      o.apc |= alu_a_pc;
      tick();
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    o.pc       = pc;
    o.instret  = instret;
  endtask

  task automatic check_vec(input string tag, input vec_t v, input obs_t o);
    check({tag, " done"},    32'(o.done), 32'd1);
    check({tag, " cycles"},  o.cycles,    v.cycles);
    check({tag, " rf_we"},   o.rf_n,      v.rf_n);
    check({tag, " wb_sel"},  32'(o.wbsel), 32'(v.wbsel));
    check({tag, " dmem_req"}, o.dreq,     v.dreq);
    check({tag, " dmem_we"}, 32'(o.dwe),  32'(v.dwe));
    check({tag, " src_imm"}, 32'(o.imm),  32'(v.imm));
    check({tag, " a_pc"},    32'(o.apc),  32'(v.apc));
    check({tag, " halt"},    32'(o.halt), 32'(v.halt));
    check({tag, " pc"},      o.pc,        v.pc);
    check({tag, " instret"}, o.instret,   v.instret);
  endtask

  vec_t vecs [12];
  vec_t v1;
  obs_t o;
  int   n;

  initial begin
    //        opc    iw dw tk target        cyc rf sel dq we im ap ht pc            instret
    vecs[0]  = '{6'd27, 0, 0, 0, 32'h0,      4, 1, 2'd0, 0, 0, 0, 0, 0, 32'h4,  32'd1};
    vecs[1]  = '{6'd27, 0, 0, 0, 32'h0,      4, 1, 2'd0, 0, 0, 0, 0, 0, 32'h8,  32'd2};
    vecs[2]  = '{6'd18, 2, 0, 0, 32'h0,      6, 1, 2'd0, 0, 0, 1, 0, 0, 32'hc,  32'd3};
    vecs[3]  = '{6'd12, 0, 3, 0, 32'h0,      8, 1, 2'd1, 4, 0, 1, 0, 0, 32'h10, 32'd4};
    vecs[4]  = '{6'd17, 0, 0, 0, 32'h0,      5, 0, 2'd0, 1, 1, 1, 0, 0, 32'h14, 32'd5};
    vecs[5]  = '{6'd4,  0, 0, 0, 32'h100,    4, 0, 2'd0, 0, 0, 1, 1, 0, 32'h18, 32'd6};
    vecs[6]  = '{6'd4,  0, 0, 1, 32'h40,     4, 0, 2'd0, 0, 0, 1, 1, 0, 32'h40, 32'd7};
    vecs[7]  = '{6'd2,  0, 0, 0, 32'h80,     4, 1, 2'd2, 0, 0, 1, 1, 0, 32'h80, 32'd8};
    vecs[8]  = '{6'd3,  0, 0, 0, 32'h91,     4, 1, 2'd2, 0, 0, 1, 0, 0, 32'h90, 32'd9};
    vecs[9]  = '{6'd0,  0, 0, 0, 32'h0,      4, 1, 2'd3, 0, 0, 0, 0, 0, 32'h94, 32'd10};
    vecs[10] = '{6'd1,  0, 0, 0, 32'h0,      4, 1, 2'd0, 0, 0, 1, 1, 0, 32'h98, 32'd11};
    vecs[11] = '{6'd4,  0, 0, 1, 32'h42,     4, 0, 2'd0, 0, 0, 1, 1, 1, 32'h98, 32'd11};

    // Reset state, sampled while rst is still high.
    rst = 1'b1;
    tick();
    tick();
    check("reset pc",       pc,               32'h0);
    check("reset instret",  instret,          32'h0);
    check("reset imem_req", 32'(imem_req),    32'd0);
    check("reset dmem_req", 32'(dmem_req),    32'd0);
    check("reset halt",     32'(halt),        32'd0);
    check("reset rf_we",    32'(rf_we),       32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_instr(vecs[i], o);
      check_vec($sformatf("vec%0d", i), vecs[i], o);
    end

    // Trap is sticky: no requests, pc frozen at the pre-trap value.
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("trap halt %0d", i),     32'(halt),     32'd1);
      check($sformatf("trap imem_req %0d", i), 32'(imem_req), 32'd0);
      check($sformatf("trap dmem_req %0d", i), 32'(dmem_req), 32'd0);
    end
    check("trap pc", pc, 32'h98);

    // Illegal opcode traps straight out of DECODE.
    do_reset();
    check("rst exits trap", 32'(halt), 32'd0);
    v1 = '{6'd63, 0, 0, 0, 32'h0, 2, 0, 2'd0, 0, 0, 0, 0, 1, 32'h0, 32'd0};
    run_instr(v1, o);
    check_vec("illegal", v1, o);

    // Reset asserted in the middle of a stalled load.
    do_reset();
    v1 = '{6'd27, 0, 0, 0, 32'h0, 4, 1, 2'd0, 0, 0, 0, 0, 0, 32'h4, 32'd1};
    run_instr(v1, o);
    check_vec("pre-mem add", v1, o);
    opcode = 6'd12;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (dmem_req) begin n = 1; break; end
      imem_ready = imem_req;
      tick();
    end
    imem_ready = 1'b0;
    check("reached MEM", n, 1);
    tick();
    check("still in MEM", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    tick();
    check("mid-mem rst dmem_req", 32'(dmem_req), 32'd0);
    check("mid-mem rst imem_req", 32'(imem_req), 32'd0);
    check("mid-mem rst pc",       pc,            32'h0);
    check("mid-mem rst instret",  instret,       32'h0);
    rst = 1'b0;

`ifdef MEM_TIMEOUT_EN
    // Fetch never answered: trap after exactly 16 requesting cycles.
    do_reset();
    opcode = 6'd27;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (halt) break;
      if (imem_req) n++;
      tick();
    end
    check("timeout req cycles", n,          16);
    check("timeout halt",       32'(halt),  32'd1);
    tick();
    check("timeout req drop",   32'(imem_req), 32'd0);

    // Ready on the 16th wait cycle wins over the timeout.
    do_reset();
    v1 = '{6'd27, 15, 0, 0, 32'h0, 19, 1, 2'd0, 0, 0, 0, 0, 0, 32'h4, 32'd1};
    run_instr(v1, o);
    check_vec("ready at limit", v1, o);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
